pipe_stage_reg: RTL



---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_skid_slot.sv | 46 ++++
 rtl/pipe_stage_reg.sv | 101 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared control-bundle layout for pipeline stage registers.
// Field offsets and the safe (no side effect) control value.
package pipe_pkg;

    localparam int CTRL_W_DEFAULT   = 8;

    localparam int CTRL_REGWRITE    = 0;
    localparam int CTRL_MEMW        = 1;
    localparam int CTRL_DATATOREG   = 2;
    localparam int CTRL_DATATOREG_W = 2;
    localparam int CTRL_BRANCH      = 4;
    localparam int CTRL_JAL         = 5;

    typedef logic [CTRL_W_DEFAULT-1:0] ctrl_t;

    localparam ctrl_t CTRL_SAFE = '0;

    // True when the bundle would change architectural state downstream.
    function automatic logic ctrl_has_side_effect(input ctrl_t c);
        return c[CTRL_REGWRITE] | c[CTRL_MEMW];
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One holding register of a pipeline stage: valid + control + data.
// Clear invalidates and forces control to the safe value; data is left alone.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                CTRL_W   = CTRL_W_DEFAULT,
    parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(CTRL_SAFE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // NOTE: state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_RST;
            // NOTE: data is reset too because out_data is observable as 0 after reset.
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_RST;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with stall, bubble and flush.
// Define PIPE_STAGE_SKID_EN to add a skid entry and register in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                CTRL_W   = CTRL_W_DEFAULT,
    parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(CTRL_SAFE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    logic              w_out_valid;
    logic [CTRL_W-1:0] w_out_ctrl;
    logic [DATA_W-1:0] w_out_data;

    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    logic              w_out_free;
    logic              w_xfer_in;
    logic              w_xfer_out;
    logic              w_out_load;
    logic              w_out_clear;
    logic [CTRL_W-1:0] w_load_ctrl;
    logic [DATA_W-1:0] w_load_data;

    assign w_out_free = !w_out_valid | out_ready;
    assign w_xfer_in  = in_valid & in_ready;
    assign w_xfer_out = w_out_valid & out_ready;

    // The skid word is older than anything arriving, so it always wins the output slot.
    assign w_out_load  = w_out_free & (w_skid_valid | w_xfer_in);
    assign w_out_clear = flush | (w_xfer_out & !w_skid_valid & !w_xfer_in);
    assign w_load_ctrl = w_skid_valid ? w_skid_ctrl : in_ctrl;
    assign w_load_data = w_skid_valid ? w_skid_data : in_data;

    pipe_skid_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_RST (CTRL_RST)
    ) u_out_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_out_load),
        .i_clear (w_out_clear),
        .i_ctrl  (w_load_ctrl),
        .i_data  (w_load_data),
        .o_valid (w_out_valid),
        .o_ctrl  (w_out_ctrl),
        .o_data  (w_out_data)
    );

`ifdef PIPE_STAGE_SKID_EN
    logic w_skid_load;
    logic w_skid_clear;

    assign w_skid_load  = w_xfer_in & !w_out_free;
    assign w_skid_clear = flush | (w_skid_valid & out_ready);

    pipe_skid_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_RST (CTRL_RST)
    ) u_skid_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );

    assign in_ready = rst_n & !w_skid_valid;
`else
    assign w_skid_valid = 1'b0;
    assign w_skid_ctrl  = CTRL_RST;
    assign w_skid_data  = '0;

    assign in_ready = rst_n & w_out_free;
`endif

    assign out_valid = w_out_valid;
    assign out_ctrl  = w_out_ctrl;
    assign out_data  = w_out_data;

endmodule
